// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path.
// Serialiser states and the byte type used by FIFO and shifter.
package uart_pkg;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 868;

    typedef logic [7:0] uart_byte_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// CPU-side byte write handshake into the UART transmit buffer.
// The CPU drives data/strobe and must hold off while full is high.
interface uart_tx_buffered_if;
    import uart_pkg::*;

    uart_byte_t uart_tx_data;
    logic       uart_wr_en;
    logic       full;

    modport master (
        output uart_tx_data,
        output uart_wr_en,
        input  full
    );

    modport slave (
        input  uart_tx_data,
        input  uart_wr_en,
        output full
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count and naturally wrapping pointers.
// Read data is shown combinationally at the read pointer.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic                  wr_ok;
    logic                  rd_ok;

    assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            unique case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO in front of a bit serialiser.
// txd is registered so the pin never glitches between bit periods.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT    = UART_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_buffered_if.slave   bus,
    output logic                txd,
    output logic                tx_idle,
    output logic                overflow
);
    localparam int BW = $clog2(CLKS_PER_BIT);

    tx_state_e              state;
    logic [BW-1:0]          baud;
    logic [2:0]             bit_cnt;
    uart_byte_t             shift;
    uart_byte_t             fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;
    logic                   pop;
    logic                   bit_end;

    assign pop     = (state == IDLE) && !fifo_empty;
    assign bit_end = (baud == BW'(CLKS_PER_BIT - 1));
    assign tx_idle = (state == IDLE) && (fifo_count == '0);
    assign bus.full = fifo_full;

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.uart_wr_en),
        .wr_data (bus.uart_tx_data),
        .rd_en   (pop),
        .rd_data (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            txd      <= 1'b1;
            baud     <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            overflow <= 1'b0;
        end else begin
            if (bus.uart_wr_en && fifo_full) overflow <= 1'b1;
            unique case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shift <= fifo_dout;
                        baud  <= '0;
                        state <= START;
                        txd   <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        state   <= DATA;
                        txd     <= shift[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud    <= '0;
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        // Next bit is shift[1] before the shift lands.
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            txd <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud  <= '0;
                        state <= IDLE;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                    txd <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Randomised bench for uart_tx_buffered against a frame-timeline model.
// Directed sequences pin the model with literal waveform expectations.
module tb_uart_tx_buffered;
    import uart_pkg::*;

    localparam int C     = 4;
    localparam int DL    = 2;
    localparam int DEPTH = 1 << DL;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic txd;
    logic tx_idle;
    logic overflow;

    uart_tx_buffered_if bus();

    uart_tx_buffered #(
        .CLKS_PER_BIT    (C),
        .FIFO_DEPTH_LOG2 (DL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .txd      (txd),
        .tx_idle  (tx_idle),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: queued bytes plus position within the current frame (-1 = idle).
    logic [7:0] mq[$];
    int         fpos = -1;
    logic [7:0] cur  = 8'h00;
    logic       movf = 1'b0;

    function automatic logic m_txd();
        int k;
        if (fpos < 0) return 1'b1;
        k = fpos / C;
        if (k == 0) return 1'b0;
        if (k <= 8) return cur[k-1];
        return 1'b1;
    endfunction

    function automatic logic m_full();
        return mq.size() == DEPTH;
    endfunction

    function automatic logic m_idle();
        return (fpos < 0) && (mq.size() == 0);
    endfunction

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic full_pre;
        if (rst) begin
            mq.delete();
            fpos = -1;
            movf = 1'b0;
        end else begin
            full_pre = m_full();
            if (fpos >= 0) begin
                fpos++;
                if (fpos == 10 * C) fpos = -1;
            end else if (mq.size() > 0) begin
                cur  = mq.pop_front();
                fpos = 0;
            end
            if (bus.uart_wr_en) begin
                if (full_pre) movf = 1'b1;
                else mq.push_back(bus.uart_tx_data);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("txd", {7'd0, txd}, {7'd0, m_txd()});
        chk("full", {7'd0, bus.full}, {7'd0, m_full()});
        chk("tx_idle", {7'd0, tx_idle}, {7'd0, m_idle()});
        chk("overflow", {7'd0, overflow}, {7'd0, movf});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        bus.uart_wr_en   = 1'b1;
        bus.uart_tx_data = d;
        tick();
        bus.uart_wr_en   = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (!m_idle() && n < budget) begin
            tick();
            n++;
        end
        if (!m_idle()) begin
            bad++;
            total++;
            $display("FAIL drain: got busy want idle after %0d cycles", budget);
        end
    endtask

    logic e55 [42] = '{1'b1,
        1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 1'b1,
        1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 1'b1,
        1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 1'b1,
        1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 1'b1,
        1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 1'b1, 1'b1,
        1'b1};

    initial begin
        logic s [42];
        logic [7:0] d;

        bus.uart_wr_en   = 1'b0;
        bus.uart_tx_data = 8'h00;
        @(negedge clk);
        do_reset();
        chk("rst_txd", {7'd0, txd}, 8'd1);
        chk("rst_full", {7'd0, bus.full}, 8'd0);
        chk("rst_idle", {7'd0, tx_idle}, 8'd1);
        chk("rst_ovf", {7'd0, overflow}, 8'd0);

        // Single 0x55 frame, literal waveform.
        wr(8'h55);
        s[0] = txd;
        for (int i = 1; i < 42; i++) begin
            tick();
            s[i] = txd;
            if (i == 1) chk("busy_55", {7'd0, tx_idle}, 8'd0);
        end
        for (int i = 0; i < 42; i++) begin
            chk($sformatf("w55[%0d]", i), {7'd0, s[i]}, {7'd0, e55[i]});
        end
        chk("idle_55", {7'd0, tx_idle}, 8'd1);

        // Back-to-back burst; first byte is popped so full waits for the 5th.
        for (int i = 1; i <= 5; i++) begin
            wr(8'(i));
            if (i == 4) chk("full_4", {7'd0, bus.full}, 8'd0);
            if (i == 5) chk("full_5", {7'd0, bus.full}, 8'd1);
        end
        // Overflow write, then keep hammering through the pop edge.
        wr(8'hAA);
        chk("ovf_set", {7'd0, overflow}, 8'd1);
        chk("ovf_full", {7'd0, bus.full}, 8'd1);
        for (int i = 0; i < 60 && m_full(); i++) wr(8'hBB);
        chk("ovf_notfull", {7'd0, bus.full}, 8'd0);
        drain(400);
        chk("ovf_sticky", {7'd0, overflow}, 8'd1);

        // Reset in the middle of a data bit with three bytes still queued.
        do_reset();
        wr(8'hF0);
        wr(8'h11);
        wr(8'h22);
        wr(8'h33);
        for (int i = 0; i < 3 * C; i++) tick();
        do_reset();
        chk("mid_txd", {7'd0, txd}, 8'd1);
        chk("mid_idle", {7'd0, tx_idle}, 8'd1);
        chk("mid_full", {7'd0, bus.full}, 8'd0);
        for (int i = 0; i < 12 * C; i++) begin
            tick();
            chk("mid_quiet", {7'd0, txd}, 8'd1);
        end

        // 0x00 then 0xFF back-to-back exercise all-low/all-high data bits.
        wr(8'h00);
        wr(8'hFF);
        drain(200);

        // Randomised traffic with rare overflow writes and resets.
        for (int n = 0; n < 3000; n++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 2) == 0 &&
                         (!m_full() || $urandom_range(0, 7) == 0)) begin
                wr(d);
            end else begin
                tick();
            end
        end
        drain(2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Transmit end of the core's UART output path.
- Accepts bytes from the CPU memory stage through the `uart_tx_data` / `uart_wr_en` / `full` handshake and buffers them in a small FIFO.
- Serialises each byte as 8N1 frames on a single `txd` line.
- Sits between the cpu top and the board pin, replacing the external tx unit.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH_LOG2, 4, FIFO holds 2**FIFO_DEPTH_LOG2 bytes; legal range 1..10.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- uart_tx_data  in  8  byte from CPU; sampled only when uart_wr_en=1.
- uart_wr_en  in  1  write strobe, one byte per cycle high.
- full  out  1  FIFO holds 2**FIFO_DEPTH_LOG2 bytes; CPU must not write while high.
- txd  out  1  serial line, idle high.
- tx_idle  out  1  FIFO empty and serialiser in IDLE.
- overflow  out  1  sticky: a write arrived while full; cleared only by rst.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: txd=1, full=0, tx_idle=1, overflow=0, FIFO count=0, read/write pointers=0, state=IDLE, bit counter=0, baud counter=0.
- Reset mid-frame: the frame is aborted and txd=1 from the cycle after the reset edge. Buffered bytes are discarded.
- FIFO:
  - Registered count, width FIFO_DEPTH_LOG2+1.
  - Pointers FIFO_DEPTH_LOG2 bits wide and wrap naturally.
  - full = (count == 2**FIFO_DEPTH_LOG2), combinational from registers.
- Write rules:
  - uart_wr_en=1 and full=0: byte stored at wptr; wptr and count increment at that edge.
  - uart_wr_en=1 and full=1: byte dropped, overflow set, no state change. This holds even if a pop happens on the same edge.
  - Simultaneous accepted write and pop: count unchanged, both pointers advance.
- Serialiser FSM: IDLE, START, DATA, STOP.
  - IDLE: if count != 0, pop the byte into the shift register, go to START, clear the baud counter. Otherwise stay; txd=1.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit counter=0.
  - DATA: txd = shift[0] for CLKS_PER_BIT cycles. Then shift right; bit counter increments; after bit 7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- txd is driven from a register (glitch-free).
- Latency: a write accepted at edge N gives a pop at edge N+1. txd=0 from the cycle after edge N+1.
- Frame timing:
  - Frame = 10*CLKS_PER_BIT cycles.
  - Back-to-back frames have exactly one IDLE cycle (txd=1) between the STOP end and the next START.
  - Inter-frame high time is therefore CLKS_PER_BIT+1 cycles.
- tx_idle = (state==IDLE) && (count==0); registered inputs, combinational output.
- Bit order: LSB first. Byte values are opaque; no parity.

Decomposition:
- Package uart_pkg:
  - enum TxState {IDLE, START, DATA, STOP}, 2 bits.
  - Localparam UART_DEFAULT_CLKS_PER_BIT = 868.
  - Typedef for the byte type.
- Sub-module sync_fifo: parameterised width/depth, write/read enables, full/empty/count outputs, same clk/rst. Its read-during-write semantics are fixed as above.
- uart_tx_buffered instantiates sync_fifo and holds the FSM, baud counter and overflow flag.

Test Plan:
- CLKS_PER_BIT=4, write 0x55 once.
  - txd low 2 cycles after the write edge for 4 cycles.
  - Then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles.
  - tx_idle=1 after STOP.
- FIFO_DEPTH_LOG2=2, write 0x01..0x04 in 4 consecutive cycles.
  - full never asserts (first byte popped) until the 5th write 0x05.
  - All five bytes appear in order, each inter-frame gap exactly CLKS_PER_BIT+1 high cycles.
- Fill to full while serialiser busy, then write 0xAA with full=1.
  - overflow=1 and 0xAA never transmitted.
  - Count unchanged; overflow stays 1 until rst.
- Write while full on the same edge as IDLE pops.
  - Write still dropped, overflow=1, count decrements by 1.
- Assert rst for 1 cycle mid-DATA of 0xF0 with 3 bytes buffered.
  - txd=1 next cycle, tx_idle=1, full=0.
  - No further frames are emitted.
- CLKS_PER_BIT=2, write 0x00 then 0xFF back-to-back.
  - Decode at mid-bit matches both bytes.
  - Stop bits sampled high; total 2*10*2+1 cycles from first START.
